// File: rtl/tmr_pkg.sv
// Shared types for the TMR fault monitor: health states, event codes and
// the event record layout.
package tmr_pkg;

  typedef enum logic [1:0] {
    HEALTHY  = 2'd0,
    DEGRADED = 2'd1,
    FAILED   = 2'd2
  } health_e;

  localparam logic [1:0] EVT_R1    = 2'd0;
  localparam logic [1:0] EVT_R2    = 2'd1;
  localparam logic [1:0] EVT_R3    = 2'd2;
  localparam logic [1:0] EVT_MULTI = 2'd3;

  // Widest replica value a record can carry; narrower values are zero-extended.
  localparam int EVT_VAL_MAX = 32;

  typedef struct packed {
    logic [1:0]             code;
    logic [EVT_VAL_MAX-1:0] value;
  } evt_rec_t;

endpackage

// File: rtl/tmr_evt_fifo.sv
// Event record buffer: circular FIFO with a valid/ready read side.
// A write while full is only taken if the head is popped in the same cycle.
module tmr_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int REC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REC_W-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop, wr_en;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign out_valid = !empty;
  // Gate the head so the record reads as zero whenever nothing is buffered.
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_comb begin
    pop      = out_valid && out_ready;
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  // Control state, cleared asynchronously so buffered records vanish at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Triple-modular-redundancy monitor: votes three replica values, counts
// per-replica faults, tracks overall health and logs non-clean samples.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLEAN_RUN  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic             clr,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic [CNT_W-1:0] fault_cnt_1,
  output logic [CNT_W-1:0] fault_cnt_2,
  output logic [CNT_W-1:0] fault_cnt_3,
  output logic [1:0]       health,
  output logic             evt_lost
);
  localparam int RUN_W = $clog2(CLEAN_RUN + 1);
  localparam int REC_W = 2 + WIDTH;

  logic             eq12, eq13, eq23, is_clean, is_multi;
  logic [2:0]       single;
  logic [WIDTH-1:0] maj;
  evt_rec_t         push_rec;
  logic             unused_rec_hi;
  logic             push, fifo_full, fifo_empty, drop;
  logic [REC_W-1:0] fifo_out;

  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  lost_q, lost_d;
  health_e               health_q, health_d;
  logic [RUN_W-1:0]      run_q, run_d;

  // Vote: classify the sample and form the bitwise majority record.
  always_comb begin
    eq12      = (q_1 == q_2);
    eq13      = (q_1 == q_3);
    eq23      = (q_2 == q_3);
    is_clean  = eq12 && eq13;
    is_multi  = !eq12 && !eq13 && !eq23;
    single[0] = eq23 && !eq12;
    single[1] = eq13 && !eq12;
    single[2] = eq12 && !eq13;
    maj       = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);
    push_rec.value = EVT_VAL_MAX'(maj);
    if (is_multi)       push_rec.code = EVT_MULTI;
    else if (single[1]) push_rec.code = EVT_R2;
    else if (single[2]) push_rec.code = EVT_R3;
    else                push_rec.code = EVT_R1;
  end

  // Upper record bits are zero padding for narrow replicas.
  assign unused_rec_hi = ^push_rec.value;

  assign push = sample_en && !is_clean;
  assign drop = push && fifo_full && !(evt_valid && evt_ready);

  tmr_evt_fifo #(.DEPTH(FIFO_DEPTH), .REC_W(REC_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_rec.code, push_rec.value[WIDTH-1:0]}),
    .out_valid (evt_valid),
    .out_ready (evt_ready),
    .out_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_code    = fifo_out[REC_W-1 -: 2];
  assign evt_value   = fifo_out[WIDTH-1:0];
  assign fault_cnt_1 = cnt_q[0];
  assign fault_cnt_2 = cnt_q[1];
  assign fault_cnt_3 = cnt_q[2];
  assign health      = health_q;
  assign evt_lost    = lost_q;

  // Saturating per-replica counters and sticky overflow flag; clr wins.
  always_comb begin
    cnt_d  = cnt_q;
    lost_d = lost_q;
    if (clr) begin
      cnt_d  = '0;
      lost_d = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (sample_en && single[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
      if (drop) lost_d = 1'b1;
    end
  end

  // Health FSM: idle cycles leave the clean-run count untouched.
  always_comb begin
    health_d = health_q;
    run_d    = run_q;
    if (clr) begin
      health_d = HEALTHY;
      run_d    = '0;
    end else if (sample_en) begin
      if (is_multi) begin
        health_d = FAILED;
        run_d    = '0;
      end else if (!is_clean) begin
        if (health_q != FAILED) health_d = DEGRADED;
        run_d = '0;
      end else if (health_q == DEGRADED) begin
        if (run_q == RUN_W'(CLEAN_RUN - 1)) begin
          health_d = HEALTHY;
          run_d    = '0;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      lost_q   <= 1'b0;
      health_q <= HEALTHY;
      run_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
      health_q <= health_d;
      run_q    <= run_d;
    end
  end

endmodule
